// File: rtl/r88_pkg.sv
// Purpose : shared types and constants for the r88 instruction fetch path.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: fetch state encoding, regblock address-select code for PC,
//           instruction length codes.
package r88_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    SETTLE = 2'd0,  // waiting for PC/regAddr to settle before sampling
    REQ    = 2'd1,  // memory read outstanding
    HOLD   = 2'd2   // complete instruction presented to the decoder
  } fetchState_t;

  // regblock address mux select that routes PC onto regAddr.
  localparam logic [1:0] REGADDR_PC = 2'd2;

  // Total instruction length in bytes.
  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

endpackage

// File: rtl/r88_fetch_if.sv
// Purpose : bundle of regblock, memory-read and decoder signals of the fetch unit.
// Latency : n/a (wiring only).
// Backpressure : decoder stalls the fetch unit through instrAccept; memory through memReady.
// Ports (master = fetch unit side):
//   regAddr/regAddrSel/incPC      : regblock PC access
//   memAddr/memRead/memReady/memData : memory read handshake
//   flush                         : branch redirect, PC already rewritten
//   instrValid/instrAccept/opcode/operand/instrLen : decoder handshake
//   busError                      : sticky memory wait timeout flag
interface r88_fetch_if;

  logic [15:0] regAddr;
  logic [1:0]  regAddrSel;
  logic        incPC;
  logic [15:0] memAddr;
  logic        memRead;
  logic        memReady;
  logic [7:0]  memData;
  logic        flush;
  logic        instrValid;
  logic        instrAccept;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instrLen;
  logic        busError;

  modport master (
    input  regAddr, memReady, memData, flush, instrAccept,
    output regAddrSel, incPC, memAddr, memRead,
           instrValid, opcode, operand, instrLen, busError
  );

  modport slave (
    output regAddr, memReady, memData, flush, instrAccept,
    input  regAddrSel, incPC, memAddr, memRead,
           instrValid, opcode, operand, instrLen, busError
  );

endinterface

// File: rtl/r88_oplen.sv
// Purpose : instruction length from the opcode's top two bits.
// Latency : combinational.
// Backpressure : none.
// Ports: opcode (in, 8) -> instrLen (out, 2): 1, 2 or 3 total bytes.
module r88_oplen
  import r88_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] instrLen
);

  // Only the length field matters; the low bits are the operation itself.
  logic unusedLowBits;
  assign unusedLowBits = ^opcode[5:0];

  always_comb begin
    instrLen = LEN3;
    case (opcode[7:6])
      2'b00:   instrLen = LEN1;
      2'b01:   instrLen = LEN2;
      default: instrLen = LEN3;
    endcase
  end

endmodule

// File: rtl/r88_fetch.sv
// Purpose : instruction fetch sequencer; reads opcode plus 0-2 operand bytes at PC.
// Latency : 1 + SETTLE_CYCLES + memory wait cycles per byte; instrValid the edge after the last byte.
// Backpressure : holds the instruction (no prefetch) until instrAccept; waits on memReady indefinitely.
// Ports:
//   sysClock, sysReset : rising-edge clock, synchronous active-high reset
//   bus (master)       : regblock PC access, memory read, decoder handshake, busError
module r88_fetch
  import r88_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,   // 2..7
  parameter int WAIT_LIMIT    = 255  // 1..255
) (
  input logic         sysClock,
  input logic         sysReset,
  r88_fetch_if.master bus
);

  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES);
  localparam logic [8:0] WAIT_MAX    = 9'(WAIT_LIMIT);

  fetchState_t state;
  logic [2:0]  settleCnt;
  logic [7:0]  waitCnt;
  logic [1:0]  byteIdx;

  logic        memReadQ;
  logic [15:0] memAddrQ;
  logic        instrValidQ;
  logic [7:0]  opcodeQ;
  logic [15:0] operandQ;
  logic [1:0]  instrLenQ;
  logic        busErrorQ;

  logic [1:0]  lenNow;
  logic [1:0]  lenTarget;
  logic        byteTaken;
  logic        lastByte;

  // Length decoded straight from the incoming byte so the opcode capture
  // cycle already knows whether the instruction is complete.
  r88_oplen uOpLen (
    .opcode   (bus.memData),
    .instrLen (lenNow)
  );

  // A byte is accepted only when nothing higher priority discards it.
  assign byteTaken = (state == REQ) && bus.memReady && !bus.flush && !sysReset;
  assign lenTarget = (byteIdx == 2'd0) ? lenNow : instrLenQ;
  assign lastByte  = ((byteIdx + 2'd1) == lenTarget);

  // incPC is decoded from the accepting memReady cycle rather than
  // registered: PC then advances on the capture edge, and the settle
  // window only has to cover the regAddr output register.
  assign bus.incPC      = byteTaken;
  assign bus.regAddrSel = REGADDR_PC;
  assign bus.memRead    = memReadQ;
  assign bus.memAddr    = memAddrQ;
  assign bus.instrValid = instrValidQ;
  assign bus.opcode     = opcodeQ;
  assign bus.operand    = operandQ;
  assign bus.instrLen   = instrLenQ;
  assign bus.busError   = busErrorQ;

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      state       <= SETTLE;
      settleCnt   <= SETTLE_INIT;
      waitCnt     <= 8'd0;
      byteIdx     <= 2'd0;
      memReadQ    <= 1'b0;
      memAddrQ    <= 16'h0000;
      instrValidQ <= 1'b0;
      opcodeQ     <= 8'h00;
      operandQ    <= 16'h0000;
      instrLenQ   <= 2'd0;
      busErrorQ   <= 1'b0;
    end else if (bus.flush) begin
      // Redirect: drop whatever is in flight, including a byte arriving now.
      state       <= SETTLE;
      settleCnt   <= SETTLE_INIT;
      waitCnt     <= 8'd0;
      byteIdx     <= 2'd0;
      memReadQ    <= 1'b0;
      instrValidQ <= 1'b0;
      operandQ    <= 16'h0000;
    end else begin
      case (state)
        SETTLE: begin
          settleCnt <= settleCnt - 3'd1;
          // The count reaches zero on this edge: regAddr is now current.
          if (settleCnt <= 3'd1) begin
            memAddrQ <= bus.regAddr;
            memReadQ <= 1'b1;
            waitCnt  <= 8'd0;
            state    <= REQ;
          end
        end

        REQ: begin
          if (bus.memReady) begin
            case (byteIdx)
              2'd0: begin
                opcodeQ   <= bus.memData;
                instrLenQ <= lenNow;
              end
              2'd1:    operandQ[7:0]  <= bus.memData;
              default: operandQ[15:8] <= bus.memData;
            endcase
            memReadQ <= 1'b0;
            if (lastByte) begin
              instrValidQ <= 1'b1;
              state       <= HOLD;
            end else begin
              byteIdx   <= byteIdx + 2'd1;
              settleCnt <= SETTLE_INIT;
              state     <= SETTLE;
            end
          end else begin
            // Timeout only flags the condition; the read keeps waiting.
            if (waitCnt != 8'hFF) begin
              waitCnt <= waitCnt + 8'd1;
            end
            if (({1'b0, waitCnt} + 9'd1) >= WAIT_MAX) begin
              busErrorQ <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (bus.instrAccept) begin
            instrValidQ <= 1'b0;
            operandQ    <= 16'h0000;
            byteIdx     <= 2'd0;
            settleCnt   <= SETTLE_INIT;
            state       <= SETTLE;
          end
        end

        default: begin
          settleCnt <= SETTLE_INIT;
          state     <= SETTLE;
        end
      endcase
    end
  end

endmodule
